cpu_mem_responder: RTL and testbench

- Memory-side responder for the CPU data port.
- Accepts the CPU's one-cycle read request (CPUEn) and its write strobe (CPUWrEn), both on CPUAddr/CPUData.
- Returns read data on CPUOut with a one-cycle CPUValid pulse after a fixed latency.
- Sits between the CPU top and on-chip data RAM and contains a word-addressed RAM of 2**ADDR_W words.

---
 rtl/cpu_mem_responder_pkg.sv | 14 +
 rtl/cpu_mem_responder_if.sv | 24 ++
 rtl/cpu_mem_responder_ram.sv | 23 ++
 rtl/cpu_mem_responder.sv | 106 ++++++++++
 tb/tb_cpu_mem_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_responder_pkg.sv
// rtl/cpu_mem_responder_pkg.sv - shared types and constants for the CPU memory responder
package cpu_mem_pkg;

  localparam int WORD_W = 32;
  localparam int LAT_CNT_W = 4;
  localparam logic [3:0] LFSR_SEED = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// rtl/cpu_mem_responder_if.sv - CPU data-port bus between the CPU top and the memory responder
interface cpu_mem_responder_if;
  import cpu_mem_pkg::*;

  logic              CPUEn;
  logic              CPUWrEn;
  logic [WORD_W-1:0] CPUAddr;
  logic [WORD_W-1:0] CPUData;
  logic              CPUValid;
  logic [WORD_W-1:0] CPUOut;
  logic              busy;
  logic              err;

  modport master (
    output CPUEn, CPUWrEn, CPUAddr, CPUData,
    input  CPUValid, CPUOut, busy, err
  );

  modport slave (
    input  CPUEn, CPUWrEn, CPUAddr, CPUData,
    output CPUValid, CPUOut, busy, err
  );

endinterface

// File: rtl/cpu_mem_responder_ram.sv
// rtl/cpu_mem_responder_ram.sv - word RAM with one synchronous write port and one combinational read port
module mem_resp_ram
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - CPU data-port responder with fixed read latency and on-chip RAM
// Optional MEM_RESP_JITTER_EN: LFSR adds 0..3 extra wait cycles per accepted read.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_mem_responder_if.slave  bus
);

  // One spare bit so RD_LAT=15 plus three jitter cycles still fits.
  localparam int CNT_W = LAT_CNT_W + 1;

  resp_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, wait_total;
  logic [ADDR_W-1:0] idx_in, idx_q, rd_idx;
  logic [WORD_W-1:0] ram_rdata, load_data, out_q;
  logic              accept, load, addr_oob, addr_lsb_unused;

  assign idx_in          = bus.CPUAddr[ADDR_W+1:2];
  assign addr_oob        = |bus.CPUAddr[WORD_W-1:ADDR_W+2];
  assign addr_lsb_unused = ^bus.CPUAddr[1:0];

`ifdef MEM_RESP_JITTER_EN
  logic [3:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n)      lfsr <= LFSR_SEED;
    else if (accept) lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  assign wait_total = CNT_W'(RD_LAT - 1) + CNT_W'(lfsr[1:0]);
`else
  assign wait_total = CNT_W'(RD_LAT - 1);
`endif

  mem_resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (bus.CPUWrEn),
    .waddr (idx_in),
    .wdata (bus.CPUData),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  // A write landing on the same edge as the response load must be returned.
  assign load_data = (bus.CPUWrEn && (idx_in == rd_idx)) ? bus.CPUData : ram_rdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    load      = 1'b0;
    rd_idx    = idx_q;
    case (state)
      IDLE, RESP: begin
        if (bus.CPUEn) begin
          accept = 1'b1;
          if (wait_total == '0) begin
            state_nxt = RESP;
            load      = 1'b1;
            rd_idx    = idx_in;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = wait_total - CNT_W'(1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          load      = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx_q <= '0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) idx_q <= idx_in;
      if (load)   out_q <= load_data;
    end
  end

  assign bus.CPUValid = (state == RESP);
  assign bus.CPUOut   = out_q;
  assign bus.busy     = (state != IDLE);
  assign bus.err      = rst_n && ((bus.CPUEn && (state == WAIT)) ||
                                  ((bus.CPUEn || bus.CPUWrEn) && addr_oob));

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - self-checking bench for cpu_mem_responder (also builds with MEM_RESP_JITTER_EN)
module tb_cpu_mem_responder;
  import cpu_mem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_mem_responder_if bus();

  cpu_mem_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: shadow memory plus the one outstanding read as (due cycle, word index).
  logic [31:0] mem_m [int];
  int          cyc = 0;
  bit          pending = 1'b0;
  int          pend_due = 0;
  int          pend_idx = 0;
  int          lat_m = 0;
  bit          was_waiting = 1'b0;
  logic [31:0] exp_out = '0;
  logic [3:0]  lfsr_m = 4'hA;
  bit          compare_en = 1'b0;
  int          valid_cnt = 0;
  logic [31:0] last_valid_data = '0;

  function automatic int widx(logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    was_waiting = pending && (cyc - 1 < pend_due);
    if (bus.CPUWrEn) mem_m[widx(bus.CPUAddr)] = bus.CPUData;
    if (!rst_n) begin
      pending = 1'b0;
      exp_out = '0;
      lfsr_m  = 4'hA;
    end else begin
      if (bus.CPUEn && !was_waiting) begin
        lat_m = RD_LAT;
`ifdef MEM_RESP_JITTER_EN
        lat_m  = lat_m + int'(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
`endif
        pending  = 1'b1;
        pend_due = cyc + lat_m - 1;
        pend_idx = widx(bus.CPUAddr);
      end
      if (pending && pend_due == cyc)
        exp_out = mem_m.exists(pend_idx) ? mem_m[pend_idx] : 32'h0;
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      chk("valid", {31'b0, bus.CPUValid}, {31'b0, pending && cyc == pend_due});
      chk("busy",  {31'b0, bus.busy},     {31'b0, pending && cyc <= pend_due});
      chk("out",   bus.CPUOut, exp_out);
      chk("err",   {31'b0, bus.err}, {31'b0, rst_n && ((bus.CPUEn && pending && cyc < pend_due) ||
              ((bus.CPUEn || bus.CPUWrEn) && bus.CPUAddr[31:ADDR_W+2] != '0))});
      if (bus.CPUValid === 1'b1) begin
        valid_cnt++;
        last_valid_data = bus.CPUOut;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d);
    bus.CPUWrEn = 1'b1; bus.CPUAddr = a; bus.CPUData = d;
    tick();
    bus.CPUWrEn = 1'b0;
  endtask

  task automatic do_read(logic [31:0] a);
    bus.CPUEn = 1'b1; bus.CPUAddr = a;
    tick();
    bus.CPUEn = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) chk("idle_timeout", 32'd1, 32'd0);
    tick();
  endtask

  int base_cnt;
  int lat;

  initial begin
    bus.CPUEn = 1'b0; bus.CPUWrEn = 1'b0; bus.CPUAddr = '0; bus.CPUData = '0;
    repeat (2) tick();
    compare_en = 1'b1;
    chk("rst_valid", {31'b0, bus.CPUValid}, 32'd0);
    chk("rst_out",   bus.CPUOut, 32'd0);
    chk("rst_busy",  {31'b0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write then read 0x10
    do_write(32'h10, 32'hDEADBEEF);
    tick();
    base_cnt = valid_cnt;
    do_read(32'h10);
`ifndef MEM_RESP_JITTER_EN
    chk("s1_busy_wait", {31'b0, bus.busy}, 32'd1);
    chk("s1_valid_early", {31'b0, bus.CPUValid}, 32'd0);
    tick();
    chk("s1_valid", {31'b0, bus.CPUValid}, 32'd1);
    chk("s1_data", bus.CPUOut, 32'hDEADBEEF);
`endif
    wait_idle();
    chk("s1_pulses", valid_cnt - base_cnt, 32'd1);
    chk("s1_last", last_valid_data, 32'hDEADBEEF);

    // Write into the pending word while the read waits
    do_write(32'h20, 32'h1111);
    base_cnt = valid_cnt;
    do_read(32'h20);
    do_write(32'h20, 32'h2222);
    wait_idle();
    chk("s2_pulses", valid_cnt - base_cnt, 32'd1);
    chk("s2_data", last_valid_data, 32'h2222);

    // Back-to-back: second request issued in the RESP cycle of the first
    do_write(32'h4, 32'h1);
    do_write(32'h8, 32'h2);
    base_cnt = valid_cnt;
    do_read(32'h4);
    lat = 1;
    while (!bus.CPUValid && lat < 20) begin
      tick();
      lat++;
    end
    do_read(32'h8);
    wait_idle();
    chk("s3_pulses", valid_cnt - base_cnt, 32'd2);
    chk("s3_last", last_valid_data, 32'h2);
    chk("s3_hold", bus.CPUOut, 32'h2);

    // Request during WAIT is rejected with err
    base_cnt = valid_cnt;
    do_read(32'h4);
    bus.CPUEn = 1'b1; bus.CPUAddr = 32'h8;
    #1;
    chk("s4_err_wait", {31'b0, bus.err}, 32'd1);
    tick();
    bus.CPUEn = 1'b0;
    wait_idle();
    chk("s4_pulses", valid_cnt - base_cnt, 32'd1);
    chk("s4_data", last_valid_data, 32'h1);

    // Out-of-range upper address bits wrap and flag err
    bus.CPUEn = 1'b1; bus.CPUAddr = 32'h0000_1004;
    #1;
    chk("s5_err_oob", {31'b0, bus.err}, 32'd1);
    tick();
    bus.CPUEn = 1'b0;
    wait_idle();
    chk("s5_data", last_valid_data, 32'h1);
    do_write(32'h0000_1008, 32'h33);
    do_read(32'h8);
    wait_idle();
    chk("s5_wr_wrap", last_valid_data, 32'h33);

    // Reset while waiting aborts the read
    base_cnt = valid_cnt;
    do_read(32'h10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s6_busy", {31'b0, bus.busy}, 32'd0);
    chk("s6_out", bus.CPUOut, 32'd0);
    repeat (6) tick();
    chk("s6_no_valid", valid_cnt - base_cnt, 32'd0);
    do_read(32'h10);
    wait_idle();
    chk("s6_after", last_valid_data, 32'hDEADBEEF);

    // Sixteen reads: latency bounds
    for (int i = 0; i < 16; i++) begin
      do_write(32'h40 + 32'(i * 4), 32'hA500_0000 + 32'(i));
      do_read(32'h40 + 32'(i * 4));
      lat = 1;
      while (!bus.CPUValid && lat < 20) begin
        tick();
        lat++;
      end
`ifdef MEM_RESP_JITTER_EN
      chk("s7_lat_range", {31'b0, lat >= 2 && lat <= 5}, 32'd1);
`else
      chk("s7_lat", 32'(lat), 32'd2);
`endif
      chk("s7_data", bus.CPUOut, 32'hA500_0000 + 32'(i));
      wait_idle();
    end

    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
